// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//   AXI4 responder that puts one AXI slave port in front of a single-port
//   synchronous SRAM macro. Only 32-bit INCR bursts of 1..16 beats are
//   supported, so size and burst type are not ported.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   AR*  / R*                    read address / read data channels
//   AW*  / W*  / B*              write address / write data / write response
//   CEB, WEB, A, DI, DO          SRAM macro interface (active-low enables;
//                                DO is valid the cycle after a read access)
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  // read address
  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  // write address
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  // write response
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // SRAM macro
  output logic              CEB,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_RADDR = 6'b000010,
    S_RWAIT = 6'b000100,
    S_RDATA = 6'b001000,
    S_WDATA = 6'b010000,
    S_WRESP = 6'b100000
  } state_t;

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic [3:0]          len, len_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ID_W-1:0]     id, id_n;
  logic                err, err_n;
  logic [31:0]         rdata_q;
  logic [ADDR_W-1:0]   a_hold;
  logic [31:0]         di_hold;

  logic                access;
  logic [3:0]          web_c;
  logic [ADDR_W-1:0]   a_c;
  logic [31:0]         di_c;
  logic                last;

  // Byte-offset and upper address bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ARADDR[31:ADDR_W+2], ARADDR[1:0],
                              AWADDR[31:ADDR_W+2], AWADDR[1:0]};

  assign last = (cnt == len);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    addr_n  = addr;
    id_n    = id;
    err_n   = err;
    ARREADY = 1'b0;
    AWREADY = 1'b0;
    RVALID  = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    access  = 1'b0;
    web_c   = 4'hF;
    a_c     = a_hold;   // A and DI keep their last driven values when idle
    di_c    = di_hold;

    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          AWREADY = 1'b1;
          ARREADY = !AWVALID;           // write wins a simultaneous request
          if (AWVALID) begin
            id_n    = AWID;
            addr_n  = AWADDR[ADDR_W+1:2];
            len_n   = AWLEN;
            cnt_n   = '0;
            err_n   = 1'b0;
            state_n = S_WDATA;
          end else if (ARVALID) begin
            // First read is issued in the handshake cycle itself.
            access  = 1'b1;
            a_c     = ARADDR[ADDR_W+1:2];
            id_n    = ARID;
            addr_n  = ARADDR[ADDR_W+1:2] + 1'b1;
            len_n   = ARLEN;
            cnt_n   = '0;
            state_n = S_RWAIT;
          end
        end
        S_RADDR: begin
          access  = 1'b1;
          a_c     = addr;
          addr_n  = addr + 1'b1;
          state_n = S_RWAIT;
        end
        S_RWAIT: state_n = S_RDATA;
        S_RDATA: begin
          RVALID = 1'b1;
          if (RREADY) begin
            if (last) begin
              state_n = S_IDLE;
            end else begin
              cnt_n   = cnt + 1'b1;
              state_n = S_RADDR;
            end
          end
        end
        S_WDATA: begin
          WREADY = 1'b1;
          if (WVALID) begin
            access = 1'b1;
            web_c  = ~WSTRB;
            a_c    = addr;
            di_c   = WDATA;
            addr_n = addr + 1'b1;
            // Our beat count is authoritative; a misplaced WLAST only flags.
            if (WLAST != last) err_n = 1'b1;
            if (last) state_n = S_WRESP;
            else      cnt_n   = cnt + 1'b1;
          end
        end
        S_WRESP: begin
          BVALID = 1'b1;
          if (BREADY) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len     <= '0;
      addr    <= '0;
      id      <= '0;
      err     <= 1'b0;
      rdata_q <= '0;
      a_hold  <= '0;
      di_hold <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len     <= len_n;
      addr    <= addr_n;
      id      <= id_n;
      err     <= err_n;
      a_hold  <= a_c;
      di_hold <= di_c;
      if (state == S_RWAIT) rdata_q <= DO;
    end
  end

  assign RID   = id;
  assign RDATA = rdata_q;
  assign RRESP = 2'b00;
  assign RLAST = (state == S_RDATA) && last && !rst;
  assign BID   = id;
  assign BRESP = (state == S_WRESP && err) ? 2'b10 : 2'b00;
  assign CEB   = !access;
  assign WEB   = web_c;
  assign A     = a_c;
  assign DI    = di_c;

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave with a behavioural byte-writable SRAM.
//   Inputs change on the falling edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID, RID, AWID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA, DI, DO;
  logic [3:0]  ARLEN, AWLEN, WSTRB, WEB;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY, CEB;
  logic [1:0]  RRESP, BRESP;
  logic [13:0] A;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rexp [16];
  logic [31:0] mem  [16384];

  always #5 clk = ~clk;

  axi_sram_slave #(.ID_W(8), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  // Synchronous single-port SRAM with active-low byte write enables.
  always @(posedge clk) begin
    if (!CEB) begin
      if (&WEB) DO <= mem[A];
      else begin
        for (int i = 0; i < 4; i++)
          if (!WEB[i]) mem[A][8*i +: 8] <= DI[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // bad_beat: beat on which WLAST is raised early (-1 for none).
  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [3:0] strb, input logic [3:0] exp_web,
                          input int bad_beat, input logic [1:0] exp_resp, input bit collide);
    logic [13:0] wa;
    wa = addr[15:2];
    @(negedge clk);
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWVALID = 1'b1;
    if (collide) begin ARVALID = 1'b1; ARADDR = 32'h0; ARLEN = 4'd0; end
    #1 check("aw_ready", AWREADY, 1'b1);
    if (collide) check("collide_arready", ARREADY, 1'b0);
    @(posedge clk);
    @(negedge clk);
    AWVALID = 1'b0; ARVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      WVALID = 1'b1; WDATA = wbuf[b]; WSTRB = strb;
      WLAST  = (b == len) || (b == bad_beat);
      #1;
      check("w_ready", WREADY, 1'b1);
      check("w_ceb", CEB, 1'b0);
      check("w_web", WEB, exp_web);
      check("w_a", A, wa);
      check("w_di", DI, wbuf[b]);
      wa = wa + 14'd1;
      @(posedge clk);
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    check("b_valid", BVALID, 1'b1);
    check("b_id", BID, id);
    check("b_resp", BRESP, exp_resp);
    check("b_wready", WREADY, 1'b0);
    check("b_ceb", CEB, 1'b1);
    BREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    BREADY = 1'b0;
    #1 check("b_done", BVALID, 1'b0);
  endtask

  // stall_beat: beat held with RREADY=0 for 5 cycles; abort_beat: rst pulsed there.
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input int stall_beat, input int abort_beat);
    logic [13:0] ra;
    ra = addr[15:2];
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARVALID = 1'b1; RREADY = 1'b1;
    #1;
    check("ar_ready", ARREADY, 1'b1);
    check("ar_ceb", CEB, 1'b0);
    check("ar_web", WEB, 4'hF);
    check("ar_a", A, ra);
    @(posedge clk);
    @(negedge clk);
    ARVALID = 1'b0;
    #1 check("rwait_rvalid", RVALID, 1'b0);
    @(posedge clk);
    @(negedge clk);
    for (int b = 0; b <= len; b++) begin
      if (b == abort_beat) begin
        rst = 1'b1;
        #1;
        check("abort_rvalid", RVALID, 1'b0);
        check("abort_ceb", CEB, 1'b1);
        check("abort_rdata", RDATA, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort_idle_arready", ARREADY, 1'b1);
        return;
      end
      if (b == stall_beat) begin
        RREADY = 1'b0;
        repeat (5) begin
          #1;
          check("stall_rvalid", RVALID, 1'b1);
          check("stall_rdata", RDATA, rexp[b]);
          check("stall_ceb", CEB, 1'b1);
          @(posedge clk);
          @(negedge clk);
        end
        RREADY = 1'b1;
      end
      #1;
      check("r_valid", RVALID, 1'b1);
      check("r_data", RDATA, rexp[b]);
      check("r_last", RLAST, b == len);
      check("r_id", RID, id);
      check("r_resp", RRESP, 2'b00);
      @(posedge clk);
      @(negedge clk);
      if (b != len) begin
        ra = ra + 14'd1;
        #1;
        check("raddr_rvalid", RVALID, 1'b0);
        check("raddr_ceb", CEB, 1'b0);
        check("raddr_a", A, ra);
        @(posedge clk);
        @(negedge clk);
        #1 check("rwait2_rvalid", RVALID, 1'b0);
        @(posedge clk);
        @(negedge clk);
      end
    end
    #1;
    check("r_end_rvalid", RVALID, 1'b0);
    check("r_end_arready", ARREADY, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    rst = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;

    // Reset state, with requests pending to confirm READYs stay low.
    repeat (2) @(negedge clk);
    AWVALID = 1'b1; ARVALID = 1'b1;
    #1;
    check("rst_arready", ARREADY, 1'b0);
    check("rst_awready", AWREADY, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_ceb", CEB, 1'b1);
    check("rst_web", WEB, 4'hF);
    check("rst_bresp", BRESP, 2'b00);
    check("rst_rdata", RDATA, 32'h0);
    AWVALID = 1'b0; ARVALID = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single write of 0xDEADBEEF to word 0x10.
    wbuf[0] = 32'hDEADBEEF;
    do_write(8'h5A, 32'h40, 0, 4'hF, 4'h0, -1, 2'b00, 1'b0);
    // Words 0x11..0x13.
    wbuf[0] = 32'hA1A1A1A1; wbuf[1] = 32'hA2A2A2A2; wbuf[2] = 32'hA3A3A3A3;
    do_write(8'h11, 32'h44, 2, 4'hF, 4'h0, -1, 2'b00, 1'b0);

    // Four-beat burst read, then the same with backpressure on beat 2.
    rexp[0] = 32'hDEADBEEF; rexp[1] = 32'hA1A1A1A1;
    rexp[2] = 32'hA2A2A2A2; rexp[3] = 32'hA3A3A3A3;
    do_read(8'h33, 32'h40, 3, -1, -1);
    do_read(8'h34, 32'h40, 3, 1, -1);

    // Partial strobe: bytes 0 and 2 of a zeroed word.
    wbuf[0] = 32'h0;
    do_write(8'h01, 32'h80, 0, 4'hF, 4'h0, -1, 2'b00, 1'b0);
    wbuf[0] = 32'hFFFFFFFF;
    do_write(8'h02, 32'h80, 0, 4'b0101, 4'b1010, -1, 2'b00, 1'b0);
    rexp[0] = 32'h00FF00FF;
    do_read(8'h03, 32'h80, 0, -1, -1);

    // Collision (write wins) with early WLAST -> SLVERR, then a clean write.
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
    do_write(8'h77, 32'h100, 1, 4'hF, 4'h0, 0, 2'b10, 1'b1);
    wbuf[0] = 32'h33333333;
    do_write(8'h78, 32'h108, 0, 4'hF, 4'h0, -1, 2'b00, 1'b0);

    // Reset on beat 2 of a 4-beat read, then a fresh read of words 0x40..0x42.
    rexp[0] = 32'hDEADBEEF; rexp[1] = 32'hA1A1A1A1;
    rexp[2] = 32'hA2A2A2A2; rexp[3] = 32'hA3A3A3A3;
    do_read(8'h44, 32'h40, 3, -1, 1);
    rexp[0] = 32'h11111111; rexp[1] = 32'h22222222; rexp[2] = 32'h33333333;
    do_read(8'h45, 32'h100, 2, -1, -1);

    // Address wrap: word 0x3FFF followed by word 0x0000.
    wbuf[0] = 32'h55555555; wbuf[1] = 32'h66666666;
    do_write(8'h09, 32'hFFFC, 1, 4'hF, 4'h0, -1, 2'b00, 1'b0);
    rexp[0] = 32'h55555555; rexp[1] = 32'h66666666;
    do_read(8'h0A, 32'hFFFC, 1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
